// File: rtl/flash_pkg.sv
// Shared definitions for the flash boot loader: address widths and the loader state encodings.
package flash_pkg;

  localparam int unsigned FlAddrW  = 22;
  localparam int unsigned RamAddrW = 20;
  // One extra bit so a full 2^20-word copy can still reach its terminal count.
  localparam int unsigned CntW     = RamAddrW + 1;

  localparam logic [2:0] LDR_IDLE    = 3'd0;
  localparam logic [2:0] LDR_START   = 3'd1;
  localparam logic [2:0] LDR_ISSUE   = 3'd2;
  localparam logic [2:0] LDR_WAIT_LO = 3'd3;
  localparam logic [2:0] LDR_WAIT_HI = 3'd4;
  localparam logic [2:0] LDR_WRITE   = 3'd5;
  localparam logic [2:0] LDR_DONE    = 3'd6;

endpackage

// File: rtl/fl_toggle_req.sv
// One flash read per req pulse: flips the toggle line, waits for the ready fall then rise,
// and flags the rise with a single-cycle rsp_valid.
module fl_toggle_req
  import flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic fl_ready,
  output logic fl_read_ctrl,
  output logic rsp_valid
);

  logic [2:0] state_q, state_d;
  logic       ctrl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE:    if (req) state_d = LDR_WAIT_LO;
      // The high level left over from the previous word is not a completion.
      LDR_WAIT_LO: if (!fl_ready) state_d = LDR_WAIT_HI;
      LDR_WAIT_HI: if (fl_ready) state_d = LDR_IDLE;
      default:     state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LDR_IDLE;
      ctrl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req && state_q == LDR_IDLE) ctrl_q <= ~ctrl_q;
    end
  end

  assign fl_read_ctrl = ctrl_q;
  assign rsp_valid    = (state_q == LDR_WAIT_HI) && fl_ready;

endmodule

// File: rtl/flash_boot_loader.sv
// Boot-time copy engine: reads WORD_COUNT words from flash through the toggle-handshake
// controller and writes them to SRAM, holding the CPU until the copy completes.
module flash_boot_loader
  import flash_pkg::*;
#(
  parameter logic [FlAddrW-1:0]  FLASH_BASE = 22'h000000,
  parameter logic [RamAddrW-1:0] RAM_BASE   = 20'h00000,
  parameter int unsigned         WORD_COUNT = 1024,
  parameter bit                  AUTO_START = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [FlAddrW-1:0]  fl_addr,
  output logic                fl_read_ctrl,
  input  logic                fl_ready,
  input  logic [15:0]         fl_data,
  output logic [RamAddrW-1:0] ram_addr,
  output logic [15:0]         ram_wdata,
  output logic                ram_we,
  input  logic                ram_ack,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic [RamAddrW-1:0] progress
);

  localparam logic [CntW-1:0] LastCnt    = CntW'(WORD_COUNT);
  localparam logic [2:0]      ResetState = AUTO_START ? LDR_START : LDR_IDLE;

  logic [2:0]      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            req;
  logic            rsp_valid;

  assign req      = (state_q == LDR_ISSUE);
  assign cnt_inc  = cnt_q + CntW'(1);
  assign progress = cnt_q[RamAddrW-1:0];

  fl_toggle_req u_toggle_req (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .fl_ready     (fl_ready),
    .fl_read_ctrl (fl_read_ctrl),
    .rsp_valid    (rsp_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ResetState;
      cnt_q     <= '0;
      fl_addr   <= FLASH_BASE;
      ram_addr  <= RAM_BASE;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        LDR_IDLE: begin
          if (start) begin
            state_q  <= LDR_START;
            cpu_hold <= 1'b1;
          end else begin
            cpu_hold <= 1'b0;
          end
        end
        LDR_START: begin
          cnt_q    <= '0;
          fl_addr  <= FLASH_BASE;
          ram_addr <= RAM_BASE;
          busy     <= 1'b1;
          cpu_hold <= 1'b1;
          state_q  <= LDR_ISSUE;
        end
        LDR_ISSUE: state_q <= LDR_WAIT_LO;
        // The toggle sub-block tracks the fall/rise; this state just waits for its response.
        LDR_WAIT_LO: begin
          if (rsp_valid) begin
            ram_wdata <= fl_data;
            ram_we    <= 1'b1;
            state_q   <= LDR_WRITE;
          end
        end
        LDR_WRITE: begin
          if (ram_ack) begin
            ram_we <= 1'b0;
            cnt_q  <= cnt_inc;
            if (cnt_inc == LastCnt) begin
              state_q  <= LDR_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              fl_addr  <= fl_addr + FlAddrW'(1);
              ram_addr <= ram_addr + RamAddrW'(1);
              state_q  <= LDR_ISSUE;
            end
          end
        end
        LDR_DONE: begin
          if (start) begin
            state_q  <= LDR_START;
            cpu_hold <= 1'b1;
          end else begin
            state_q <= LDR_IDLE;
          end
        end
        default: state_q <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: three configurations driven by behavioural flash/SRAM models,
// with a table of copy runs, hand-written corner sequences and randomised re-runs.
module tb_flash_boot_loader;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [N];
  logic        start     [N];
  logic        inj       [N];
  logic        fl_ready  [N] = '{default: 1'b1};
  logic [15:0] fl_data   [N] = '{default: 16'h0};
  logic        ack_m     [N] = '{default: 1'b0};
  logic [21:0] fl_addr   [N];
  logic        fl_ctrl   [N];
  logic [19:0] ram_addr  [N];
  logic [15:0] ram_wdata [N];
  logic        ram_we    [N];
  logic        cpu_hold  [N];
  logic        busy      [N];
  logic        done      [N];
  logic [19:0] progress  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    flash_boot_loader #(
      .FLASH_BASE ((g == 2) ? 22'h3FFFFF : 22'h000100),
      .RAM_BASE   ((g == 0) ? 20'h00000 : (g == 1) ? 20'h00040 : 20'h12345),
      .WORD_COUNT ((g == 2) ? 1 : 4),
      .AUTO_START (g != 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst_n[g]),
      .start        (start[g]),
      .fl_addr      (fl_addr[g]),
      .fl_read_ctrl (fl_ctrl[g]),
      .fl_ready     (fl_ready[g]),
      .fl_data      (fl_data[g]),
      .ram_addr     (ram_addr[g]),
      .ram_wdata    (ram_wdata[g]),
      .ram_we       (ram_we[g]),
      .ram_ack      (ack_m[g] | inj[g]),
      .cpu_hold     (cpu_hold[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .progress     (progress[g])
    );
  end

  function automatic logic [21:0] fb_of(input int i);
    return (i == 2) ? 22'h3FFFFF : 22'h000100;
  endfunction
  function automatic logic [19:0] rb_of(input int i);
    return (i == 0) ? 20'h00000 : (i == 1) ? 20'h00040 : 20'h12345;
  endfunction
  // Reference for the k-th write of a run: consecutive addresses from each base, data = flash addr.
  function automatic logic [35:0] exp_wr(input int i, input int k);
    logic [19:0] a;
    logic [21:0] f;
    a = rb_of(i) + 20'(k);
    f = fb_of(i) + 22'(k);
    return {a, f[15:0]};
  endfunction

  // Behavioural flash controller and SRAM, one process for all instances.
  int          ack_dly [N];
  int          hold_hi [N];
  int          edges [N], dcyc [N], dpul [N], viol [N], wcnt [N];
  logic [35:0] wlog [N][64];
  int          fs [N], fcnt [N], flat [N], rcnt [N];
  logic        last_ctrl [N] = '{default: 1'b0};
  logic        prev_ctrl [N] = '{default: 1'b0};
  logic        prev_done [N] = '{default: 1'b0};
  logic [21:0] fa0 [N];
  bit          rpend [N];
  logic [19:0] ra [N];
  logic [15:0] rd [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fl_ctrl[i] !== prev_ctrl[i]) begin
        edges[i]++;
        if (ram_we[i] === 1'b1) viol[i]++;
      end
      prev_ctrl[i] = fl_ctrl[i];
      if (done[i] === 1'b1) begin
        dcyc[i]++;
        if (prev_done[i] !== 1'b1) dpul[i]++;
      end
      prev_done[i] = done[i];
      if (fs[i] == 1 && ram_we[i] === 1'b1) viol[i]++;

      case (fs[i])
        0: begin
          if (fl_ctrl[i] !== last_ctrl[i]) begin
            last_ctrl[i] = fl_ctrl[i];
            fa0[i]       = fl_addr[i];
            flat[i]      = $urandom_range(3, 9);
            if (hold_hi[i] > 0) begin
              fs[i]   = 1;
              fcnt[i] = hold_hi[i];
            end else begin
              fs[i]       = 2;
              fcnt[i]     = flat[i];
              fl_ready[i] = 1'b0;
            end
          end
        end
        1: begin
          fcnt[i]--;
          if (fcnt[i] == 0) begin
            fs[i]       = 2;
            fcnt[i]     = flat[i];
            fl_ready[i] = 1'b0;
          end
        end
        default: begin
          fcnt[i]--;
          if (fcnt[i] == 0) begin
            if (rst_n[i] === 1'b1 && fl_addr[i] !== fa0[i]) viol[i]++;
            fl_data[i]  = fa0[i][15:0];
            fl_ready[i] = 1'b1;
            fs[i]       = 0;
          end
        end
      endcase

      if (rst_n[i] !== 1'b1) begin
        rpend[i] = 1'b0;
        ack_m[i] = 1'b0;
      end else if (ack_m[i]) begin
        ack_m[i] = 1'b0;
      end else if (ram_we[i] === 1'b1) begin
        if (!rpend[i]) begin
          rpend[i] = 1'b1;
          ra[i]    = ram_addr[i];
          rd[i]    = ram_wdata[i];
          rcnt[i]  = ack_dly[i];
        end else if (ram_addr[i] !== ra[i] || ram_wdata[i] !== rd[i]) begin
          viol[i]++;
        end
        if (rcnt[i] == 0) begin
          ack_m[i]               = 1'b1;
          rpend[i]               = 1'b0;
          wlog[i][wcnt[i] % 64]  = {ra[i], rd[i]};
          wcnt[i]++;
        end else begin
          rcnt[i]--;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input int i, input string tag);
    check({tag, " fl_addr"},   64'(fl_addr[i]), 64'(fb_of(i)));
    check({tag, " fl_ctrl"},   64'(fl_ctrl[i]), 64'd0);
    check({tag, " ram_addr"},  64'(ram_addr[i]), 64'(rb_of(i)));
    check({tag, " ram_wdata"}, 64'(ram_wdata[i]), 64'd0);
    check({tag, " ram_we"},    64'(ram_we[i]), 64'd0);
    check({tag, " cpu_hold"},  64'(cpu_hold[i]), 64'd1);
    check({tag, " busy"},      64'(busy[i]), 64'd0);
    check({tag, " done"},      64'(done[i]), 64'd0);
    check({tag, " progress"},  64'(progress[i]), 64'd0);
  endtask

  int s_w, s_e, s_dc, s_dp, s_v;

  task automatic snap(input int i);
    s_w  = wcnt[i];
    s_e  = edges[i];
    s_dc = dcyc[i];
    s_dp = dpul[i];
    s_v  = viol[i];
  endtask

  task automatic finish_run(input int i, input int ew, input logic [35:0] elast,
                            input string tag);
    int n;
    int got;
    n = 0;
    while (dpul[i] == s_dp && n < 4000) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, 64'(dpul[i] != s_dp), 64'd1);
    tick();
    check({tag, " done low"},  64'(done[i]), 64'd0);
    check({tag, " hold low"},  64'(cpu_hold[i]), 64'd0);
    check({tag, " busy low"},  64'(busy[i]), 64'd0);
    check({tag, " progress"},  64'(progress[i]), 64'(ew));
    got = wcnt[i] - s_w;
    check({tag, " words"}, 64'(got), 64'(ew));
    for (int k = 0; k < ew && k < got; k++)
      check($sformatf("%s wr%0d", tag, k), 64'(wlog[i][(s_w + k) % 64]), 64'(exp_wr(i, k)));
    if (got > 0) check({tag, " last"}, 64'(wlog[i][(wcnt[i] - 1) % 64]), 64'(elast));
    check({tag, " edges"},     64'(edges[i] - s_e), 64'(ew));
    check({tag, " done cyc"},  64'(dcyc[i] - s_dc), 64'd1);
    check({tag, " done puls"}, 64'(dpul[i] - s_dp), 64'd1);
    check({tag, " stable"},    64'(viol[i] - s_v), 64'd0);
  endtask

  typedef struct {
    int          inst;
    int          how;       // 0: reset release (auto start), 1: start pulse
    int          ack;
    int          hold;
    int          exp_words;
    logic [35:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{0, 0, 2,  0,  4, 36'h00003_0103};
    vecs[1] = '{0, 0, 20, 0,  4, 36'h00003_0103};
    vecs[2] = '{0, 0, 2,  10, 4, 36'h00003_0103};
    vecs[3] = '{1, 1, 2,  0,  4, 36'h00043_0103};
    vecs[4] = '{1, 1, 5,  3,  4, 36'h00043_0103};
    vecs[5] = '{2, 0, 1,  0,  1, 36'h12345_FFFF};

    for (int i = 0; i < N; i++) begin
      rst_n[i]   = 1'b1;
      start[i]   = 1'b0;
      inj[i]     = 1'b0;
      ack_dly[i] = 2;
      hold_hi[i] = 0;
    end
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b0;
    #2;
    for (int i = 0; i < N; i++) check_reset(i, $sformatf("por%0d", i));
    repeat (3) tick();
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    tick();
    tick();
    check("idle1 hold", 64'(cpu_hold[1]), 64'd0);
    check("idle1 busy", 64'(busy[1]), 64'd0);
    check("auto0 busy", 64'(busy[0]), 64'd1);
    check("auto0 hold", 64'(cpu_hold[0]), 64'd1);
    repeat (300) tick();

    foreach (vecs[v]) begin
      ack_dly[vecs[v].inst] = vecs[v].ack;
      hold_hi[vecs[v].inst] = vecs[v].hold;
      if (vecs[v].how == 0) begin
        rst_n[vecs[v].inst] = 1'b0;
        repeat (15) tick();
        snap(vecs[v].inst);
        rst_n[vecs[v].inst] = 1'b1;
      end else begin
        snap(vecs[v].inst);
        start[vecs[v].inst] = 1'b1;
        tick();
        start[vecs[v].inst] = 1'b0;
      end
      finish_run(vecs[v].inst, vecs[v].exp_words, vecs[v].exp_last, $sformatf("vec%0d", v));
    end

    // start while busy is ignored; a stray ack outside a write is ignored.
    ack_dly[1] = 2;
    hold_hi[1] = 0;
    snap(1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (progress[1] != 20'd1 && n < 2000) begin
      tick();
      n++;
    end
    check("B word1", 64'(progress[1]), 64'd1);
    check("B busy", 64'(busy[1]), 64'd1);
    check("B hold", 64'(cpu_hold[1]), 64'd1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    if (ram_we[1] == 1'b0) begin
      inj[1] = 1'b1;
      tick();
      inj[1] = 1'b0;
      check("B stray ack", 64'(progress[1]), 64'd1);
    end
    finish_run(1, 4, 36'h00043_0103, "B");

    // Asynchronous reset after two words, then a clean restart from word 0.
    ack_dly[0] = 2;
    hold_hi[0] = 0;
    rst_n[0] = 1'b0;
    repeat (15) tick();
    rst_n[0] = 1'b1;
    n = 0;
    while (progress[0] != 20'd2 && n < 2000) begin
      tick();
      n++;
    end
    check("C word2", 64'(progress[0]), 64'd2);
    repeat (3) tick();
    #2;
    rst_n[0] = 1'b0;
    #1;
    check_reset(0, "C async");
    repeat (30) tick();
    snap(0);
    rst_n[0] = 1'b1;
    finish_run(0, 4, 36'h00003_0103, "C");

    // Randomised re-runs against the reference write list.
    for (int r = 0; r < 6; r++) begin
      ack_dly[1] = $urandom_range(0, 6);
      hold_hi[1] = $urandom_range(0, 4);
      snap(1);
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      finish_run(1, 4, exp_wr(1, 3), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
